drum_mul_arbiter: RTL and testbench
===================================

Name: drum_mul_arbiter

Overview:
- Shares one combinational 8x8 main_drum approximate multiplier between two independent requesters.
- Each requester has a valid/ready request channel (operands) and a valid/ready response channel (16-bit product).
- A round-robin arbiter grants the multiplier. Operands and product are registered around the multiplier.
- A 3-state FSM sequences each operation. Sits between requester datapath blocks and the DRUM core.

Parameters:
- DATA_W, 8, operand width; fixed by main_drum, only legal value is 8.
- CNT_W, 16, width of per-requester completed-operation counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a  input  DATA_W  requester 0 operand A
- req0_b  input  DATA_W  requester 0 operand B
- rsp0_valid  output  1  product for requester 0 available
- rsp0_ready  input  1  requester 0 consumes product
- rsp0_prod  output  2*DATA_W  product for requester 0
- req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_prod: same as requester 0, for requester 1
- busy  output  1  FSM not in IDLE
- done_cnt0  output  CNT_W  completed responses to requester 0
- done_cnt1  output  CNT_W  completed responses to requester 1

Behaviour:
- Reset: all outputs 0.
  - State IDLE; op_a, op_b, prod_q, owner all 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Transfers: a request transfers when reqN_valid && reqN_ready. A response transfers when rspN_valid && rspN_ready.
- Requester protocol: requesters hold valid and operands stable until ready.
- Ready rule: reqN_ready may depend combinationally on reqN_valid. It is high only in a grant cycle, and only for the granted requester.
- Grant cycle is either:
  - IDLE with any valid, or
  - HOLD in the cycle the response transfers, with any valid.
- Arbitration:
  - One valid: grant it.
  - Both valid: grant !last_grant.
  - On grant, last_grant <= granted index.
- State IDLE:
  - On grant: capture op_a/op_b, owner <= index, go to CALC.
  - Otherwise stay in IDLE.
- State CALC (always one cycle):
  - prod_q <= main_drum(op_a, op_b).
  - Go to HOLD.
- State HOLD:
  - rsp[owner]_valid = 1 and rsp[owner]_prod = prod_q. The other response channel stays 0 (valid and product).
  - prod_q stays stable while valid && !ready.
  - On response transfer: done_cnt[owner] increments, wrapping at 2^CNT_W to 0.
  - Same cycle, if a grant occurs: capture new operands and go to CALC (back-to-back). Otherwise go to IDLE.
- Latency: request accepted in cycle t -> rspN_valid high from cycle t+2. Peak throughput is one operation per 2 cycles.
- No response transfer in HOLD: remain in HOLD. reqN_ready stays 0 for both requesters, so no starvation bypass.
- Requester drops valid before grant: permitted, nothing is captured.
- Response acknowledged by the non-owner: ignored. Only owner's rsp_ready counts.
- Reset asserted mid-operation: immediate return to reset values. The in-flight operation is discarded and no response is issued.
- busy = (state != IDLE).

Decomposition:
- Shared package drum_pkg holds:
  - DRUM_W = 8
  - state encoding IDLE=2'd0, CALC=2'd1, HOLD=2'd2; 2'd3 is illegal and recovers to IDLE.
- Sub-modules:
  - drum_rr_arb2: combinational 2-way round-robin grant from valids and last_grant.
  - main_drum: existing multiplier, instantiated unchanged.

Test Plan:
- Basic product:
  - Stimulus: req0 a=8'd3, b=8'd5, rsp0_ready=1.
  - Response: req0_ready in cycle t; rsp0_valid at t+2 with 16'd15; done_cnt0=1; rsp1_valid stays 0.
- Approximate product:
  - Stimulus: req1 a=8'h62, b=8'hA2.
  - Response: rsp1_prod equals a standalone golden main_drum driven with the same operands; exact mismatch count 0 over 256 random pairs.
- Fairness:
  - Stimulus: both valid continuously, both rsp_ready=1.
  - Response: grants alternate 0,1,0,1; each requester gets 1 result per 4 cycles; after 100 ops done_cnt0=done_cnt1=50.
- Backpressure:
  - Stimulus: rsp0_ready=0 for 10 cycles.
  - Response: rsp0_valid and prod stable for 10 cycles; req1_ready=0 throughout; release gives one transfer and same-cycle grant to req1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during CALC.
  - Response: all outputs 0 asynchronously; no response after release; next tie grants requester 0.
- Counter wrap:
  - Stimulus: CNT_W=4, 16 ops on req0.
  - Response: done_cnt0 returns to 0.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM multiplier arbiter: widths, FSM encoding
// and the operand truncation used by the approximate multiplier.
package drum_pkg;

    localparam int DRUM_W = 8;
    // Number of significant bits kept from each operand by the DRUM core.
    localparam int DRUM_K = 4;

    // 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [DRUM_K-1:0] mant;
        logic [2:0]        shift;
    } drum_trunc_t;

    // Keep the DRUM_K bits starting at the leading one; when bits are dropped
    // the kept LSB is forced to 1 so the truncation error is unbiased.
    function automatic drum_trunc_t drum_trunc(input logic [DRUM_W-1:0] x);
        drum_trunc_t r;
        int          lead;
        lead = 0;
        for (int i = 0; i < DRUM_W; i++) begin
            if (x[i]) lead = i;
        end
        if (lead < DRUM_K) begin
            r.mant  = x[DRUM_K-1:0];
            r.shift = 3'd0;
        end else begin
            r.shift = 3'(lead - DRUM_K + 1);
            r.mant  = DRUM_K'(x >> r.shift) | DRUM_K'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/drum_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester that was not granted last time.
module drum_rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    // Pure combinational choice; the caller owns last_grant.
    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_idx   = (valid0 && valid1) ? ~last_grant : valid1;
    end

endmodule

// File: rtl/main_drum.sv
// Combinational 8x8 DRUM approximate multiplier. Operands below 2^DRUM_K
// multiply exactly; larger ones are truncated to DRUM_K significant bits.
module main_drum
    import drum_pkg::*;
(
    input  logic [DRUM_W-1:0]   a,
    input  logic [DRUM_W-1:0]   b,
    output logic [2*DRUM_W-1:0] prod
);

    drum_trunc_t         ta;
    drum_trunc_t         tb;
    logic [2*DRUM_W-1:0] mant_prod;
    logic [3:0]          shift;

    // Multiply the truncated mantissas and restore the dropped magnitude.
    always_comb begin
        ta        = drum_trunc(a);
        tb        = drum_trunc(b);
        mant_prod = (2*DRUM_W)'(ta.mant) * (2*DRUM_W)'(tb.mant);
        shift     = {1'b0, ta.shift} + {1'b0, tb.shift};
        prod      = mant_prod << shift;
    end

endmodule

// File: rtl/drum_mul_arbiter.sv
// Shares one DRUM multiplier between two valid/ready requesters.
// Handshake: a request moves when reqN_valid && reqN_ready, a response moves
// when rspN_valid && rspN_ready; reqN_ready is high only in a grant cycle
// (IDLE, or HOLD while the response transfers) and only for the winner.
module drum_mul_arbiter
    import drum_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [2*DATA_W-1:0] rsp0_prod,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [2*DATA_W-1:0] rsp1_prod,
    output logic                busy,
    output logic [CNT_W-1:0]    done_cnt0,
    output logic [CNT_W-1:0]    done_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [2*DATA_W-1:0] prod_q;
    logic [2*DATA_W-1:0] drum_prod;
    logic                owner;
    logic                last_grant;
    logic                gnt_valid;
    logic                gnt_idx;
    logic                rsp_xfer;
    logic                grant_window;
    logic                do_grant;

    drum_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    main_drum u_drum (
        .a    (op_a),
        .b    (op_b),
        .prod (drum_prod)
    );

    // Handshake decode; rst_n gating keeps every output at 0 during reset.
    always_comb begin
        rsp_xfer     = (state_q == HOLD) && (owner ? rsp1_ready : rsp0_ready);
        grant_window = rst_n && ((state_q == IDLE) || rsp_xfer);
        do_grant     = grant_window && gnt_valid;
        req0_ready   = do_grant && !gnt_idx;
        req1_ready   = do_grant && gnt_idx;
        rsp0_valid   = (state_q == HOLD) && !owner;
        rsp1_valid   = (state_q == HOLD) && owner;
        rsp0_prod    = rsp0_valid ? prod_q : '0;
        rsp1_prod    = rsp1_valid ? prod_q : '0;
        busy         = (state_q != IDLE);
    end

    // Next-state logic: IDLE -> CALC on grant, CALC -> HOLD always,
    // HOLD leaves only when the owner takes the product.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_grant) state_d = CALC;
            CALC:    state_d = HOLD;
            HOLD:    if (rsp_xfer) state_d = do_grant ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand capture, product register, round-robin history and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            prod_q     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            if (do_grant) begin
                owner      <= gnt_idx;
                last_grant <= gnt_idx;
                op_a       <= gnt_idx ? req1_a : req0_a;
                op_b       <= gnt_idx ? req1_b : req0_b;
            end
            if (state_q == CALC) prod_q <= drum_prod;
            if (rsp_xfer) begin
                if (owner) done_cnt1 <= done_cnt1 + CNT_ONE;
                else       done_cnt0 <= done_cnt0 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Directed bench for drum_mul_arbiter: reset, exact and approximate products,
// fairness, backpressure, reset mid-operation and counter wrap.
module tb_drum_mul_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [15:0] rsp0_prod, rsp1_prod, done_cnt0, done_cnt1;
    logic        busy;

    // Narrow-counter instance for the wrap test.
    logic        w_req0_valid, w_req0_ready, w_rsp0_valid, w_rsp0_ready;
    logic        w_req1_valid, w_req1_ready, w_rsp1_valid, w_rsp1_ready;
    logic [7:0]  w_req0_a, w_req0_b, w_req1_a, w_req1_b;
    logic [15:0] w_rsp0_prod, w_rsp1_prod;
    logic [3:0]  w_done_cnt0, w_done_cnt1;
    logic        w_busy;

    logic [68:0] all_outs;
    assign all_outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                       rsp0_prod, rsp1_prod, done_cnt0, done_cnt1};

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt0 = 16'd0;
    logic [15:0] exp_cnt1 = 16'd0;

    drum_mul_arbiter #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_prod(rsp0_prod),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_prod(rsp1_prod),
        .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    drum_mul_arbiter #(.DATA_W(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(w_rsp0_ready), .rsp0_prod(w_rsp0_prod),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_req1_a), .req1_b(w_req1_b),
        .rsp1_valid(w_rsp1_valid), .rsp1_ready(w_rsp1_ready), .rsp1_prod(w_rsp1_prod),
        .busy(w_busy), .done_cnt0(w_done_cnt0), .done_cnt1(w_done_cnt1)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference DRUM: shift right until the value fits in 4 bits, set the LSB
    // if anything was dropped, multiply and shift back.
    function automatic logic [15:0] golden_drum(input logic [7:0] a, input logic [7:0] b);
        int ta, tb, na, nb;
        ta = a; na = 0;
        while (ta >= 16) begin ta = ta >> 1; na++; end
        if (na > 0) ta = ta | 1;
        tb = b; nb = 0;
        while (tb >= 16) begin tb = tb >> 1; nb++; end
        if (nb > 0) tb = tb | 1;
        return 16'((ta * tb) << (na + nb));
    endfunction

    // Driver: one operation on requester idx with its rsp_ready already high.
    // Returns at the falling edge where the response is visible.
    task automatic run_op(input bit idx, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int lat, output bit to);
        int n;
        prod = '0; lat = 0; to = 1'b0;
        @(posedge clk); #1;
        if (idx) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(idx ? req1_ready : req0_ready) && n < 20);
        if (!(idx ? req1_ready : req0_ready)) begin
            to = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        do begin @(negedge clk); lat++; end
        while (!(idx ? rsp1_valid : rsp0_valid) && lat < 20);
        if (!(idx ? rsp1_valid : rsp0_valid)) to = 1'b1;
        else prod = idx ? rsp1_prod : rsp0_prod;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; rsp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; rsp1_ready = 0;
        w_req0_valid = 0; w_req0_a = 0; w_req0_b = 0; w_rsp0_ready = 0;
        w_req1_valid = 0; w_req1_a = 0; w_req1_b = 0; w_rsp1_ready = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h, want 0", all_outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b, want 0", busy); end
    endtask

    task automatic test_basic();
        logic [15:0] p; int lat; bit to;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        run_op(1'b0, 8'd3, 8'd5, p, lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: handshake bound expired"); end
        checks++;
        if (p !== 16'd15) begin errors++; $display("FAIL basic_prod: got %0d, want 15", p); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d, want 2", lat); end
        checks++;
        if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL basic_other_rsp: rsp1_valid=%b, want 0", rsp1_valid); end
        exp_cnt0++;
        @(negedge clk);
        checks++;
        if (done_cnt0 !== exp_cnt0) begin errors++; $display("FAIL basic_cnt: got %0d, want %0d", done_cnt0, exp_cnt0); end
    endtask

    task automatic test_approx();
        logic [15:0] p; int lat; bit to;
        logic [7:0]  va [5] = '{8'h62, 8'd255, 8'd16, 8'd15, 8'd0};
        logic [7:0]  vb [5] = '{8'hA2, 8'd255, 8'd16, 8'd15, 8'd200};
        logic [15:0] vp [5] = '{16'h4780, 16'hE100, 16'h0144, 16'h00E1, 16'h0000};
        logic [7:0]  ra, rb;
        int mism;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, va[i], vb[i], p, lat, to);
            exp_cnt1++;
            checks++;
            if (to || p !== vp[i]) begin
                errors++;
                $display("FAIL approx_vec%0d: a=%h b=%h got %h, want %h (timeout=%b)", i, va[i], vb[i], p, vp[i], to);
            end
        end
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(1'b1, ra, rb, p, lat, to);
            exp_cnt1++;
            checks++;
            if (to || p !== golden_drum(ra, rb)) begin
                errors++; mism++;
                $display("FAIL approx_rand: a=%h b=%h got %h, want %h", ra, rb, p, golden_drum(ra, rb));
            end
        end
        @(negedge clk);
        checks++;
        if (done_cnt1 !== exp_cnt1) begin errors++; $display("FAIL approx_cnt: got %0d, want %0d", done_cnt1, exp_cnt1); end
    endtask

    task automatic test_fairness();
        int gnts, cyc, last_cyc;
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd2; req0_b = 8'd3;
        req1_valid = 1; req1_a = 8'd4; req1_b = 8'd5;
        rsp0_ready = 1; rsp1_ready = 1;
        gnts = 0; cyc = 0; last_cyc = 0;
        while (gnts < 100 && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (req0_ready && req1_ready) begin
                checks++; errors++; $display("FAIL fair_double_grant: both ready at cycle %0d", cyc);
            end else if (req0_ready || req1_ready) begin
                checks++;
                if (req1_ready !== gnts[0]) begin
                    errors++; $display("FAIL fair_order: grant %0d went to %0d, want %0d", gnts, req1_ready, gnts[0]);
                end
                if (gnts > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 2) begin
                        errors++; $display("FAIL fair_gap: gap %0d cycles, want 2", cyc - last_cyc);
                    end
                end
                last_cyc = cyc; gnts++;
            end
            if (rsp0_valid) begin
                checks++;
                if (rsp0_prod !== 16'd6) begin errors++; $display("FAIL fair_prod0: got %0d, want 6", rsp0_prod); end
            end
            if (rsp1_valid) begin
                checks++;
                if (rsp1_prod !== 16'd20) begin errors++; $display("FAIL fair_prod1: got %0d, want 20", rsp1_prod); end
            end
        end
        checks++;
        if (gnts < 100) begin errors++; $display("FAIL fair_timeout: got %0d grants, want 100", gnts); end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(negedge clk);
        exp_cnt0 += 16'd50; exp_cnt1 += 16'd50;
        checks++;
        if (done_cnt0 !== exp_cnt0) begin errors++; $display("FAIL fair_cnt0: got %0d, want %0d", done_cnt0, exp_cnt0); end
        checks++;
        if (done_cnt1 !== exp_cnt1) begin errors++; $display("FAIL fair_cnt1: got %0d, want %0d", done_cnt1, exp_cnt1); end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 1;
        req0_valid = 1; req0_a = 8'd7; req0_b = 8'd9;
        req1_valid = 1; req1_a = 8'd2; req1_b = 8'd2;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_first_grant: ready0=%b ready1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_calc_ready1: got %b, want 0", req1_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_prod !== 16'd63 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b prod=%0d ready1=%b, want 1 63 0", i, rsp0_valid, rsp0_prod, req1_ready);
            end
        end
        @(posedge clk); #1;
        rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release: ready1=%b rsp0_valid=%b, want 1 1", req1_ready, rsp0_valid);
        end
        @(posedge clk); #1;
        req1_valid = 0;
        exp_cnt0++;
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b1 || done_cnt0 !== exp_cnt0) begin
            errors++;
            $display("FAIL bp_after: rsp0_valid=%b busy=%b cnt0=%0d, want 0 1 %0d", rsp0_valid, busy, done_cnt0, exp_cnt0);
        end
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_prod !== 16'd4) begin
            errors++; $display("FAIL bp_rsp1: valid=%b prod=%0d, want 1 4", rsp1_valid, rsp1_prod);
        end
        exp_cnt1++;
        @(negedge clk);
        checks++;
        if (done_cnt1 !== exp_cnt1) begin errors++; $display("FAIL bp_cnt1: got %0d, want %0d", done_cnt1, exp_cnt1); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 8'd9; req0_b = 8'd9;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got %b, want 1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt0 = 16'd0; exp_cnt1 = 16'd0;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL rstmid_async: got %h, want 0", all_outs); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_no_rsp: activity after reset, want none"); end
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd1; req0_b = 8'd1;
        req1_valid = 1; req1_a = 8'd1; req1_b = 8'd1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_tie: ready0=%b ready1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        exp_cnt0++;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt0 !== exp_cnt0 || done_cnt1 !== exp_cnt1) begin
            errors++; $display("FAIL rstmid_cnt: cnt0=%0d cnt1=%0d, want %0d %0d", done_cnt0, done_cnt1, exp_cnt0, exp_cnt1);
        end
    endtask

    task automatic test_counter_wrap();
        int n;
        logic [3:0] exp_w;
        exp_w = 4'd0;
        w_rsp0_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            w_req0_valid = 1; w_req0_a = 8'(i); w_req0_b = 8'd1;
            n = 0;
            do begin @(negedge clk); n++; end while (!w_req0_ready && n < 20);
            @(posedge clk); #1;
            w_req0_valid = 0;
            n = 0;
            do begin @(negedge clk); n++; end while (!w_rsp0_valid && n < 20);
            @(negedge clk);
            exp_w = exp_w + 4'd1;
            checks++;
            if (w_done_cnt0 !== exp_w) begin
                errors++; $display("FAIL wrap_cnt%0d: got %0d, want %0d", i, w_done_cnt0, exp_w);
            end
        end
        checks++;
        if (w_done_cnt0 !== 4'd0) begin errors++; $display("FAIL wrap_final: got %0d, want 0", w_done_cnt0); end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_basic();
        test_approx();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
